// File: rtl/isa_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
package isa_pkg;
  localparam int REG_IDX_W = 3;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of shift-add multiply or restoring divide.
// Shared state layout: multiply uses st[2W-1:0] as the accumulator; divide uses {rem[W:0], quo[W-1:0]}.
module mdu_step #(
  parameter int WIDTH = 16
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   st,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH:0]   st_next
);
  logic [WIDTH:0]   hi_sum;
  logic [2*WIDTH:0] shl;
  logic [WIDTH+1:0] trial;

  always_comb begin
    hi_sum  = {1'b0, st[2*WIDTH-1:WIDTH]} + (st[0] ? {1'b0, b} : '0);
    shl     = {st[2*WIDTH-1:0], 1'b0};
    // Remainder after the shift, one spare top bit so the sign of the trial is visible.
    trial   = {st[2*WIDTH:WIDTH-1]} - {2'b00, b};
    st_next = {1'b0, hi_sum, st[WIDTH-1:1]};
    if (is_div) begin
      st_next = shl;
      if (!trial[WIDTH+1]) begin
        st_next[2*WIDTH:WIDTH] = trial[WIDTH:0];
        st_next[0]             = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 16-bit unsigned multiply/divide with a one-cycle register-file write-back.
module mul_div_unit
  import isa_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  input  logic [REG_IDX_W-1:0] rd_in,
  output logic                 busy,
  output logic                 wb,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [WIDTH-1:0]     wb_data
);
  localparam int CNT_W = $clog2(WIDTH);

  state_e               state;
  logic [CNT_W-1:0]     cnt;
  op_e                  op_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH:0]     st_p0;
  logic [2*WIDTH:0]     st_next;
  logic                 accept;
  logic                 div_zero;
  logic                 is_div;

  function automatic logic [WIDTH-1:0] pick_result(input op_e o, input logic [2*WIDTH:0] s);
    case (o)
      OP_MUL, OP_DIVU: pick_result = s[WIDTH-1:0];
      default:         pick_result = s[2*WIDTH-1:WIDTH];
    endcase
  endfunction

  assign accept   = (state == ST_IDLE) && start;
  assign div_zero = op[1] && (rt_data == '0);
  assign is_div   = (op_q == OP_DIVU) || (op_q == OP_REMU);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .st      (st_p0),
    .b       (b_q),
    .st_next (st_next)
  );

  // Stage p0: operand/iteration registers, loaded at accept and stepped in RUN.
  // A zero divisor preloads {rem, quo} so DIVU reads all ones and REMU reads the dividend.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= op_e'(op);
      rd_q  <= rd_in;
      b_q   <= rt_data;
      st_p0 <= div_zero ? {1'b0, rs_data, {WIDTH{1'b1}}} : {{(WIDTH+1){1'b0}}, rs_data};
    end else if (state == ST_RUN) begin
      st_p0 <= st_next;
    end
  end

  // Control and registered write-back outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      wb      <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            if (div_zero) begin
              state   <= ST_DONE;
              wb      <= 1'b1;
              wb_rd   <= rd_in;
              wb_data <= (op_e'(op) == OP_DIVU) ? {WIDTH{1'b1}} : rs_data;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state   <= ST_DONE;
            wb      <= 1'b1;
            wb_rd   <= rd_q;
            wb_data <= pick_result(op_q, st_next);
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          wb      <= 1'b0;
          wb_rd   <= '0;
          wb_data <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes expected write-backs, a negedge monitor checks them.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] rs_data = '0;
  logic [15:0] rt_data = '0;
  logic [2:0]  rd_in = '0;
  logic        busy;
  logic        wb;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    int          at_cyc;
  } exp_t;
  exp_t sbq[$];

  mul_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .rd_in   (rd_in),
    .busy    (busy),
    .wb      (wb),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain unsigned arithmetic with the divide-by-zero conventions.
  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (o)
      2'b00:   model = p[15:0];
      2'b01:   model = p[31:16];
      2'b10:   model = (b == 0) ? 16'hFFFF : a / b;
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every negedge, either a write-back to score or quiet outputs.
  always @(negedge clk) begin
    if (wb) begin
      if (sbq.size() == 0) begin
        chk("unexpected_wb", {16'h0, wb_data}, 32'hDEAD);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("wb_data", {16'h0, wb_data}, {16'h0, e.data});
        chk("wb_rd", {29'h0, wb_rd}, {29'h0, e.rd});
        chk("wb_cycle", cyc, e.at_cyc);
      end
    end else begin
      chk("idle_wb_data", {16'h0, wb_data}, 32'h0);
      chk("idle_wb_rd", {29'h0, wb_rd}, 32'h0);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] rd, input logic [15:0] exp, output int k);
    int waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (busy) chk("issue_wait_busy", 32'h1, 32'h0);
    start = 1'b1; op = o; rs_data = a; rt_data = b; rd_in = rd;
    @(posedge clk);
    #1 k = cyc;
    e.rd = rd;
    e.data = exp;
    e.at_cyc = k + ((o[1] && b == 16'h0) ? 0 : 16);
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int k;
    logic [1:0]  ro;
    logic [15:0] ra, rb;
    logic [2:0]  rr;

    // Reset, then idle with everything low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_wb", {31'h0, wb}, 32'h0);
    end

    issue(2'b00, 16'h1234, 16'h0010, 3'd3, 16'h2340, k);
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
    wait_cyc(k + 16);
    chk("busy_in_done", {31'h0, busy}, 32'h1);
    wait_cyc(k + 17);
    chk("busy_after_done", {31'h0, busy}, 32'h0);

    issue(2'b01, 16'hFFFF, 16'hFFFF, 3'd1, 16'hFFFE, k);
    issue(2'b00, 16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, k);
    issue(2'b10, 16'd100, 16'd7, 3'd5, 16'h000E, k);
    issue(2'b11, 16'd100, 16'd7, 3'd4, 16'h0002, k);
    issue(2'b10, 16'h0005, 16'h0009, 3'd6, 16'h0000, k);
    issue(2'b11, 16'h0005, 16'h0009, 3'd7, 16'h0005, k);
    issue(2'b10, 16'h1234, 16'h0000, 3'd1, 16'hFFFF, k);
    issue(2'b11, 16'h1234, 16'h0000, 3'd0, 16'h1234, k);
    chk("div0_busy_e0", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("div0_busy_e1", {31'h0, busy}, 32'h0);

    // Starts while busy, mid-RUN and at the edge leaving DONE, are dropped.
    issue(2'b00, 16'h00FF, 16'h0101, 3'd6, 16'hFFFF, k);
    wait_cyc(k + 2);
    start = 1'b1; op = 2'b10; rs_data = 16'h4321; rt_data = 16'h0003; rd_in = 3'd1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(k + 16);
    start = 1'b1; op = 2'b01; rs_data = 16'h7777; rt_data = 16'h0002; rd_in = 3'd2;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", {31'h0, busy}, 32'h0);
    repeat (20) @(negedge clk);

    // Reset in the middle of a divide aborts it without a write-back.
    issue(2'b10, 16'd1000, 16'd3, 3'd2, 16'd333, k);
    wait_cyc(k + 7);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_wb", {31'h0, wb}, 32'h0);
    chk("abort_wb_data", {16'h0, wb_data}, 32'h0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    issue(2'b00, 16'd3, 16'd4, 3'd3, 16'h000C, k);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = 16'h0;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      rr = 3'($urandom_range(0, 7));
      issue(ro, ra, rb, rr, model(ro, ra, rb), k);
    end

    repeat (25) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
